// File: rtl/mem_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and data memory (slave).
interface mem_stage_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic            we;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic            ready;
   logic [XLEN-1:0] rdata;

   modport master (output req, we, addr, wdata, input ready, rdata);
   modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: ALU results pass through in one cycle; loads/stores run a
// req/ready access with timeout abort, stalling EX while the access is open.
module mem_stage #(
   parameter int XLEN    = 32,
   parameter int REGW    = 5,
   parameter int TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            EX_valid,
   input  logic [XLEN-1:0] EX_alu_out,
   input  logic [XLEN-1:0] EX_b2,
   input  logic [REGW-1:0] EX_rd,
   input  logic            EX_we,
   input  logic            EX_ld,
   input  logic            EX_st,
   output logic            MEM_stall,
   mem_stage_if.master     dm,
   output logic            WB_valid,
   output logic [XLEN-1:0] WB_data,
   output logic [REGW-1:0] WB_rd,
   output logic            WB_we,
   output logic            WB_err
);
   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   typedef struct packed {
      logic            req;
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [REGW-1:0] rd;
      logic            rd_we;
      logic            ld;
   } acc_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] data;
      logic [REGW-1:0] rd;
      logic            we;
      logic            err;
   } wb_t;

   state_t        state_q, state_d;
   acc_t          acc_q, acc_d;
   wb_t           wb_q, wb_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         wb_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         wb_q    <= wb_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      wb_d    = wb_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            wb_d.valid = 1'b0;
            if (EX_valid) begin
               if (EX_ld || EX_st) begin
                  state_d     = BUSY;
                  acc_d.req   = 1'b1;
                  // Load takes priority when both flags are set.
                  acc_d.we    = EX_st && !EX_ld;
                  acc_d.addr  = EX_alu_out;
                  acc_d.wdata = EX_b2;
                  acc_d.rd    = EX_rd;
                  acc_d.rd_we = EX_we;
                  acc_d.ld    = EX_ld;
                  cnt_d       = '0;
               end else begin
                  wb_d.valid = 1'b1;
                  wb_d.data  = EX_alu_out;
                  wb_d.rd    = EX_rd;
                  wb_d.we    = EX_we && (EX_rd != '0);
                  wb_d.err   = 1'b0;
               end
            end
         end
         BUSY: begin
            // A ready response in the final wait cycle still completes normally.
            if (dm.ready) begin
               state_d    = IDLE;
               acc_d.req  = 1'b0;
               wb_d.valid = 1'b1;
               wb_d.err   = 1'b0;
               wb_d.rd    = acc_q.rd;
               if (acc_q.ld) begin
                  wb_d.data = dm.rdata;
                  wb_d.we   = acc_q.rd_we && (acc_q.rd != '0);
               end else begin
                  wb_d.data = '0;
                  wb_d.we   = 1'b0;
               end
            end else if (cnt_q == CNT_MAX) begin
               state_d    = IDLE;
               acc_d.req  = 1'b0;
               wb_d.valid = 1'b1;
               wb_d.err   = 1'b1;
               wb_d.rd    = acc_q.rd;
               wb_d.we    = 1'b0;
               wb_d.data  = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign MEM_stall = (state_q == BUSY);
   assign dm.req    = acc_q.req;
   assign dm.we     = acc_q.we;
   assign dm.addr   = acc_q.addr;
   assign dm.wdata  = acc_q.wdata;
   assign WB_valid  = wb_q.valid;
   assign WB_data   = wb_q.data;
   assign WB_rd     = wb_q.rd;
   assign WB_we     = wb_q.we;
   assign WB_err    = wb_q.err;
endmodule
